// File: rtl/score_digit_sprite_ctrl.sv
// Score overlay sequencer: maps the scan coordinate onto DIGITS sprite boxes, drives the shared
// digit-ROM address and returns an aligned pixel/hit three cycles after the coordinate is sampled.
module score_digit_sprite_ctrl #(
    parameter int          DIGITS = 3,
    parameter logic [9:0]  X0     = 10'd560,
    parameter logic [9:0]  Y0     = 10'd20,
    parameter int          SPR_W  = 20,
    parameter int          SPR_H  = 20,
    parameter logic [7:0]  TRANSP = 8'h00
) (
    input  logic                  i_clk2,
    input  logic                  i_reset,
    input  logic [9:0]            i_x,
    input  logic [9:0]            i_y,
    input  logic                  i_active,
    input  logic                  i_frame_start,
    input  logic [4*DIGITS-1:0]   i_score,
    input  logic                  i_score_wr,
    output logic                  o_score_pending,
    output logic [9:0]            o_numberaddr,
    input  logic [79:0]           i_numberdata,
    output logic [7:0]            o_pixel,
    output logic                  o_hit
);

    localparam logic [10:0] Y_END = 11'(Y0) + 11'(SPR_H);

    logic [4*DIGITS-1:0] disp_r, pend_r, disp_next_s, pend_next_s;
    logic                pending_next_s;
    logic [DIGITS-1:0]   box_hit_s;
    logic [1:0]          d_s;
    logic [3:0]          nib_s, v_s, v1_r, v2_r;
    logic                ms_zero_s, lz_s, in_y_s, inbox_s, blank_s;
    logic [9:0]          col_s, row_s, addr_s;
    logic [10:0]         x_s, y_s;
    logic                inbox1_r, blank1_r, inbox2_r, blank2_r;
    logic [7:0]          sel_s, pix_next_s;
    logic                hit_next_s;

    // Score update: a write coinciding with frame start goes straight to the display.
    always_comb begin
        disp_next_s    = disp_r;
        pend_next_s    = pend_r;
        pending_next_s = o_score_pending;
        if (i_score_wr && i_frame_start) begin
            disp_next_s    = i_score;
            pending_next_s = 1'b0;
        end else if (i_frame_start && o_score_pending) begin
            disp_next_s    = pend_r;
            pending_next_s = 1'b0;
        end else if (i_score_wr) begin
            pend_next_s    = i_score;
            pending_next_s = 1'b1;
        end else begin
            pending_next_s = o_score_pending;
        end
    end

    // Box decode; uses the post-update score so a frame-start edge already shows the new value.
    always_comb begin
        x_s       = {1'b0, i_x};
        y_s       = {1'b0, i_y};
        in_y_s    = (y_s >= 11'(Y0)) && (y_s < Y_END);
        box_hit_s = '0;
        d_s       = 2'd0;
        v_s       = 4'd0;
        nib_s     = 4'd0;
        ms_zero_s = 1'b1;
        lz_s      = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            box_hit_s[k] = (x_s >= 11'(X0) + 11'(k * SPR_W)) &&
                           (x_s <  11'(X0) + 11'((k + 1) * SPR_W));
            nib_s = disp_next_s[4*(DIGITS-1-k) +: 4];
            d_s   = d_s | (box_hit_s[k] ? 2'(k) : 2'd0);
            v_s   = v_s | (box_hit_s[k] ? nib_s : 4'd0);
            // leading zero only if all boxes to the left were zero; the last box always shows
            lz_s  = lz_s | (box_hit_s[k] && ms_zero_s && (nib_s == 4'd0) && (k != DIGITS - 1));
            ms_zero_s = ms_zero_s && (nib_s == 4'd0);
        end
        inbox_s = i_active && in_y_s && (|box_hit_s);
        col_s   = 10'(x_s - 11'(X0) - 11'(d_s) * 11'(SPR_W));
        row_s   = 10'(y_s - 11'(Y0));
        addr_s  = inbox_s ? 10'(row_s * 10'(SPR_W) + col_s) : 10'd0;
        blank_s = (v_s > 4'd9) || lz_s;
    end

    // Digit ROM output select and final hit decision.
    always_comb begin
        sel_s = TRANSP;
        for (int k = 0; k < 10; k++) begin
            sel_s = (v2_r == 4'(k)) ? i_numberdata[8*k +: 8] : sel_s;
        end
        hit_next_s = inbox2_r && !blank2_r && (sel_s != TRANSP);
        pix_next_s = hit_next_s ? sel_s : TRANSP;
    end

    // Score registers and the three pipeline stages.
    always_ff @(posedge i_clk2 or posedge i_reset) begin
        if (i_reset) begin
            disp_r          <= '0;
            pend_r          <= '0;
            o_score_pending <= 1'b0;
            o_numberaddr    <= 10'd0;
            inbox1_r        <= 1'b0;
            v1_r            <= 4'd0;
            blank1_r        <= 1'b0;
            inbox2_r        <= 1'b0;
            v2_r            <= 4'd0;
            blank2_r        <= 1'b0;
            o_pixel         <= TRANSP;
            o_hit           <= 1'b0;
        end else begin
            disp_r          <= disp_next_s;
            pend_r          <= pend_next_s;
            o_score_pending <= pending_next_s;
            o_numberaddr    <= addr_s;
            inbox1_r        <= inbox_s;
            v1_r            <= v_s;
            blank1_r        <= blank_s;
            inbox2_r        <= inbox1_r;
            v2_r            <= v1_r;
            blank2_r        <= blank1_r;
            o_pixel         <= pix_next_s;
            o_hit           <= hit_next_s;
        end
    end

endmodule

// File: tb/tb_score_digit_sprite_ctrl.sv
// Scoreboard bench for score_digit_sprite_ctrl with a behavioural ROM and an independent pixel model.
module tb_score_digit_sprite_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  x, y;
    logic        active, fs, wr;
    logic [11:0] score;
    logic        pending;
    logic [9:0]  addr;
    logic [79:0] ndata;
    logic [7:0]  pixel;
    logic        hit;

    int errors = 0;
    int checks = 0;

    logic [11:0] m_disp, m_pend;
    logic        m_pending;
    logic [8:0]  q[$];

    score_digit_sprite_ctrl dut (
        .i_clk2(clk), .i_reset(rst), .i_x(x), .i_y(y), .i_active(active),
        .i_frame_start(fs), .i_score(score), .i_score_wr(wr),
        .o_score_pending(pending), .o_numberaddr(addr), .i_numberdata(ndata),
        .o_pixel(pixel), .o_hit(hit)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_val(int k, int a);
        if (a % 5 == 0) return 8'h00;
        return 8'((k * 29 + a * 13 + 1) ^ (a >> 2));
    endfunction

    // ten 1-cycle registered digit ROMs sharing one address
    always_ff @(posedge clk) begin
        for (int k = 0; k < 10; k++) ndata[8*k +: 8] <= rom_val(k, int'(addr));
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // returns {addr[9:0], hit, pixel[7:0]}
    function automatic logic [18:0] model(int px, int py, logic act, logic [11:0] disp);
        int d, col, row, a;
        logic [3:0] v;
        logic blank, hz;
        logic [7:0] sel;
        if (!(act && px >= 560 && px < 620 && py >= 20 && py < 40)) return {10'd0, 1'b0, 8'h00};
        d = (px - 560) / 20;
        col = (px - 560) % 20;
        row = py - 20;
        a = row * 20 + col;
        v = disp[4*(2-d) +: 4];
        blank = (v > 4'd9);
        if (v == 4'd0 && d < 2) begin
            hz = 1'b1;
            for (int j = 0; j < d; j++) if (disp[4*(2-j) +: 4] != 4'd0) hz = 1'b0;
            if (hz) blank = 1'b1;
        end
        sel = (v <= 4'd9) ? rom_val(int'(v), a) : 8'h00;
        if (blank || sel == 8'h00) return {10'(a), 1'b0, 8'h00};
        return {10'(a), 1'b1, sel};
    endfunction

    task automatic step(input int px, input int py, input logic act, input logic w,
                        input logic [11:0] sc, input logic f);
        logic [18:0] e;
        logic [8:0] o;
        x = 10'(px); y = 10'(py); active = act; wr = w; score = sc; fs = f;
        if (w && f) begin m_disp = sc; m_pending = 1'b0; end
        else if (f && m_pending) begin m_disp = m_pend; m_pending = 1'b0; end
        else if (w) begin m_pend = sc; m_pending = 1'b1; end
        e = model(px, py, act, m_disp);
        q.push_back(e[8:0]);
        @(posedge clk); #1;
        check_eq("addr", 32'(addr), 32'(e[18:9]));
        check_eq("pending", 32'(pending), 32'(m_pending));
        if (q.size() == 3) begin
            o = q.pop_front();
            check_eq("hit", 32'(hit), 32'(o[8]));
            check_eq("pixel", 32'(pixel), 32'(o[7:0]));
        end
    endtask

    task automatic raster(input int py, input int xa, input int xb);
        for (int px = xa; px <= xb; px++) step(px, py, 1'b1, 1'b0, 12'h000, 1'b0);
    endtask

    task automatic model_reset();
        m_disp = 12'h000; m_pend = 12'h000; m_pending = 1'b0;
        q.delete();
    endtask

    function automatic logic [11:0] rand_score();
        return {4'($urandom_range(0, 10)), 4'($urandom_range(0, 10)), 4'($urandom_range(0, 10))};
    endfunction

    initial begin
        model_reset();
        rst = 1'b1; x = 10'd605; y = 10'd25; active = 1'b1; fs = 1'b0; wr = 1'b0; score = 12'h000;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            check_eq("rst_hit", 32'(hit), 32'd0);
            check_eq("rst_pixel", 32'(pixel), 32'd0);
            check_eq("rst_addr", 32'(addr), 32'd0);
            check_eq("rst_pending", 32'(pending), 32'd0);
        end
        rst = 1'b0;
        raster(25, 595, 625);

        // 306: middle zero is not leading, so it draws ROM 0
        step(0, 0, 1'b0, 1'b1, 12'h306, 1'b0);
        raster(20, 556, 600);
        step(0, 0, 1'b0, 1'b0, 12'h000, 1'b1);
        raster(20, 556, 623);
        raster(31, 556, 623);

        // 007 via simultaneous write and frame start
        step(0, 0, 1'b0, 1'b1, 12'h007, 1'b1);
        raster(20, 556, 623);
        raster(39, 596, 618);
        step(619, 39, 1'b1, 1'b0, 12'h000, 1'b0);
        check_eq("addr399", 32'(addr), 32'd399);
        raster(39, 620, 622);

        // 123 written mid-frame stays pending until frame start
        step(0, 0, 1'b0, 1'b1, 12'h123, 1'b0);
        raster(25, 556, 623);
        check_eq("pend_held", 32'(pending), 32'd1);
        step(0, 0, 1'b0, 1'b0, 12'h000, 1'b1);
        check_eq("pend_clr", 32'(pending), 32'd0);
        raster(25, 556, 623);

        // stale pend dropped by a simultaneous write + frame start
        step(0, 0, 1'b0, 1'b1, 12'h999, 1'b0);
        step(0, 0, 1'b0, 1'b1, 12'hA05, 1'b1);
        raster(30, 555, 625);
        raster(19, 560, 619);
        raster(40, 560, 619);
        for (int px = 560; px < 620; px++) step(px, 30, 1'b0, 1'b0, 12'h000, 1'b0);

        // asynchronous reset mid-raster
        raster(33, 600, 610);
        rst = 1'b1;
        #1;
        check_eq("arst_hit", 32'(hit), 32'd0);
        check_eq("arst_pixel", 32'(pixel), 32'd0);
        check_eq("arst_addr", 32'(addr), 32'd0);
        @(posedge clk); #1;
        check_eq("arst_hold", 32'(hit), 32'd0);
        rst = 1'b0;
        model_reset();
        raster(33, 595, 625);

        // three reduced frames with random scores and enables
        for (int f = 0; f < 3; f++) begin
            step(0, 0, 1'b0, 1'($urandom_range(0, 1)), rand_score(), 1'b1);
            for (int py = 10; py < 50; py++) begin
                for (int px = 540; px < 640; px++) begin
                    step(px, py, 1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 299) == 0),
                         rand_score(), 1'b0);
                end
            end
        end
        for (int i = 0; i < 500; i++) begin
            step($urandom_range(0, 639), $urandom_range(0, 479), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 49) == 0), rand_score(), 1'($urandom_range(0, 99) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
